// File: rtl/three_of_five_tx.sv
// 3-of-5 constant-weight transmitter: digit in over valid/ready, codeword serialized LSB-first.
// Latency: first bit on tx_bit one cycle after the accepting edge; ready is low for the whole frame.
module three_of_five_tx #(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit_in,
    input  logic       digit_valid,
    output logic       digit_ready,
    output logic       tx_bit,
    output logic       tx_frame,
    output logic       tx_active,
    output logic [4:0] code_out,
    output logic       err_pulse,
    output logic [7:0] frame_count
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [7:0] CNT_LAST = 8'(BIT_CYCLES - 1);

    state_t     state_q;
    logic [3:0] shift_q;
    logic [2:0] idx_q;
    logic [7:0] cnt_q;
    logic [4:0] code_q;
    logic [7:0] fc_q;
    logic       ready_q, bit_q, frame_q, active_q, err_q;

    logic [4:0] enc_d;
    logic       take_d;

    function automatic logic [4:0] encode(input logic [3:0] d);
        case (d)
            4'd0:    encode = 5'b00111;
            4'd1:    encode = 5'b01011;
            4'd2:    encode = 5'b01101;
            4'd3:    encode = 5'b01110;
            4'd4:    encode = 5'b10011;
            4'd5:    encode = 5'b10101;
            4'd6:    encode = 5'b10110;
            4'd7:    encode = 5'b11001;
            4'd8:    encode = 5'b11010;
            4'd9:    encode = 5'b11100;
            default: encode = 5'b00000;
        endcase
    endfunction

    assign enc_d  = encode(digit_in);
    assign take_d = digit_valid && ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= 4'd0;
            idx_q    <= 3'd0;
            cnt_q    <= 8'd0;
            code_q   <= 5'd0;
            fc_q     <= 8'd0;
            ready_q  <= 1'b0;
            bit_q    <= 1'b0;
            frame_q  <= 1'b0;
            active_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (take_d) begin
                        if (digit_in <= 4'd9) begin
                            state_q  <= SHIFT;
                            code_q   <= enc_d;
                            // bit 0 goes straight to the line; the rest waits in the shifter
                            shift_q  <= enc_d[4:1];
                            bit_q    <= enc_d[0];
                            idx_q    <= 3'd0;
                            cnt_q    <= 8'd0;
                            frame_q  <= 1'b1;
                            active_q <= 1'b1;
                            ready_q  <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= 8'd0;
                        if (idx_q == 3'd4) begin
                            state_q  <= IDLE;
                            active_q <= 1'b0;
                            bit_q    <= 1'b0;
                            frame_q  <= 1'b0;
                            ready_q  <= 1'b1;
                            fc_q     <= fc_q + 8'd1;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            bit_q   <= shift_q[0];
                            shift_q <= {1'b0, shift_q[3:1]};
                            frame_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign digit_ready = ready_q;
    assign tx_bit      = bit_q;
    assign tx_frame    = frame_q;
    assign tx_active   = active_q;
    assign code_out    = code_q;
    assign err_pulse   = err_q;
    assign frame_count = fc_q;

endmodule

// File: tb/tb_three_of_five_tx.sv
// Bench for three_of_five_tx: one instance at BIT_CYCLES=1, one at BIT_CYCLES=3, checked against a frame-offset model.
module tb_three_of_five_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vld   [2];
    logic [3:0] dig   [2];
    logic       rdy   [2];
    logic       txb   [2];
    logic       txf   [2];
    logic       txa   [2];
    logic [4:0] code  [2];
    logic       err   [2];
    logic [7:0] fc    [2];

    int nvec = 0;
    int nbad = 0;
    int bc [2] = '{1, 3};

    always #5 clk = ~clk;

    three_of_five_tx #(.BIT_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .digit_in(dig[0]), .digit_valid(vld[0]),
        .digit_ready(rdy[0]), .tx_bit(txb[0]), .tx_frame(txf[0]), .tx_active(txa[0]),
        .code_out(code[0]), .err_pulse(err[0]), .frame_count(fc[0])
    );
    three_of_five_tx #(.BIT_CYCLES(3)) u3 (
        .clk(clk), .rst(rst), .digit_in(dig[1]), .digit_valid(vld[1]),
        .digit_ready(rdy[1]), .tx_bit(txb[1]), .tx_frame(txf[1]), .tx_active(txa[1]),
        .code_out(code[1]), .err_pulse(err[1]), .frame_count(fc[1])
    );

    // codeword for d = d-th 5-bit value, ascending, with exactly three ones
    function automatic logic [4:0] ref_code(input int d);
        int n = 0;
        ref_code = 5'd0;
        for (int v = 0; v < 32; v++) begin
            if ($countones(5'(v)) == 3) begin
                if (n == d) ref_code = 5'(v);
                n++;
            end
        end
    endfunction

    // model: m_pos is the cycle offset inside the current frame, -1 when idle
    int         m_pos   [2];
    logic       m_ready [2];
    logic       m_err   [2];
    logic [4:0] m_code  [2];
    logic [7:0] m_fc    [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_pos[i] <= -1; m_ready[i] <= 1'b0; m_err[i] <= 1'b0;
                m_code[i] <= 5'd0; m_fc[i] <= 8'd0;
            end else if (m_pos[i] >= 0) begin
                m_err[i] <= 1'b0;
                if (m_pos[i] == 5 * bc[i] - 1) begin
                    m_pos[i] <= -1; m_fc[i] <= m_fc[i] + 8'd1; m_ready[i] <= 1'b1;
                end else begin
                    m_pos[i] <= m_pos[i] + 1;
                end
            end else begin
                m_ready[i] <= 1'b1;
                m_err[i]   <= 1'b0;
                if (vld[i] && m_ready[i]) begin
                    if (dig[i] <= 4'd9) begin
                        m_code[i] <= ref_code(int'(dig[i]));
                        m_pos[i] <= 0; m_ready[i] <= 1'b0;
                    end else begin
                        m_err[i] <= 1'b1;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        nvec++;
        if (got != want) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic act, frm, b;
            act = (m_pos[i] >= 0);
            frm = act && (m_pos[i] < bc[i]);
            b   = act ? m_code[i][m_pos[i] / bc[i]] : 1'b0;
            chk($sformatf("u%0d.digit_ready", bc[i]), int'(rdy[i]), int'(m_ready[i]));
            chk($sformatf("u%0d.tx_active", bc[i]), int'(txa[i]), int'(act));
            chk($sformatf("u%0d.tx_frame", bc[i]), int'(txf[i]), int'(frm));
            chk($sformatf("u%0d.tx_bit", bc[i]), int'(txb[i]), int'(b));
            chk($sformatf("u%0d.code_out", bc[i]), int'(code[i]), int'(m_code[i]));
            chk($sformatf("u%0d.err_pulse", bc[i]), int'(err[i]), int'(m_err[i]));
            chk($sformatf("u%0d.frame_count", bc[i]), int'(fc[i]), int'(m_fc[i]));
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ready(input int i);
        int n = 0;
        while (!rdy[i] && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("ready_timeout", 0, 1);
    endtask

    task automatic send(input int i, input logic [3:0] d);
        wait_ready(i);
        dig[i] = d; vld[i] = 1'b1;
        @(negedge clk);
        vld[i] = 1'b0;
    endtask

    // records tx_bit over n cycles starting at the current negedge, first bit at index 0
    task automatic capture(input int i, input int n, output logic [14:0] bits,
                           output int nfrm, output int nact);
        bits = '0; nfrm = 0; nact = 0;
        for (int k = 0; k < n; k++) begin
            bits[k] = txb[i];
            nfrm += int'(txf[i]);
            nact += int'(txa[i]);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [14:0] bits;
        int nfrm, nact, n;
        logic seen;
        vld[0] = 1'b0; vld[1] = 1'b0; dig[0] = 4'd0; dig[1] = 4'd0;
        @(negedge clk);
        chk("reset.digit_ready", int'(rdy[0]), 0);
        chk("model.code9", int'(ref_code(9)), 5'b11100);
        chk("model.code4", int'(ref_code(4)), 5'b10011);

        // 1: reset release and digit 0
        do_reset();
        chk("post_reset.ready_low", int'(rdy[0]), 0);
        @(negedge clk);
        chk("post_reset.ready_high", int'(rdy[0]), 1);
        send(0, 4'd0);
        capture(0, 7, bits, nfrm, nact);
        chk("t1.bits", int'(bits[4:0]), 5'b00111);
        chk("t1.frame_cycles", nfrm, 1);
        chk("t1.active_cycles", nact, 5);
        chk("t1.frame_count", int'(fc[0]), 1);

        // 2: digits 0..9 with valid held high
        do_reset();
        vld[0] = 1'b1;
        for (int d = 0; d < 10; d++) begin
            wait_ready(0);
            dig[0] = 4'(d);
            @(negedge clk);
        end
        vld[0] = 1'b0;
        repeat (7) @(negedge clk);
        chk("t2.frame_count", int'(fc[0]), 10);
        chk("t2.last_code", int'(code[0]), 5'b11100);

        // 3: illegal 12 then 7
        send(0, 4'd12);
        chk("t3.err_high", int'(err[0]), 1);
        chk("t3.no_active", int'(txa[0]), 0);
        @(negedge clk);
        chk("t3.err_low", int'(err[0]), 0);
        chk("t3.fc_unchanged", int'(fc[0]), 10);
        send(0, 4'd7);
        capture(0, 5, bits, nfrm, nact);
        chk("t3.bits", int'(bits[4:0]), 5'b11001);

        // 4: BIT_CYCLES=3, digit 5
        send(1, 4'd5);
        capture(1, 16, bits, nfrm, nact);
        chk("t4.bits", int'(bits), 15'b111000111000111);
        chk("t4.frame_cycles", nfrm, 3);
        chk("t4.active_cycles", nact, 15);

        // 5: reset during bit 2 of digit 9
        repeat (3) @(negedge clk);
        send(0, 4'd9);
        repeat (2) @(negedge clk);
        chk("t5.in_bit2", int'(txb[0]), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5.rst_active", int'(txa[0]), 0);
        chk("t5.rst_bit", int'(txb[0]), 0);
        chk("t5.rst_code", int'(code[0]), 0);
        chk("t5.rst_fc", int'(fc[0]), 0);
        rst = 1'b0;
        send(0, 4'd1);
        capture(0, 6, bits, nfrm, nact);
        chk("t5.bits", int'(bits[4:0]), 5'b01011);
        chk("t5.frame_count", int'(fc[0]), 1);

        // 6: 256 frames with noise on the inputs during SHIFT
        do_reset();
        seen = 1'b0;
        n = 0;
        while (n < 3000) begin
            if (rdy[0]) begin
                vld[0] = 1'b1; dig[0] = 4'($urandom_range(0, 9));
            end else begin
                vld[0] = 1'($urandom_range(0, 1)); dig[0] = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
            n++;
            if (m_fc[0] == 8'd255) seen = 1'b1;
            if (seen && m_fc[0] == 8'd0) break;
        end
        vld[0] = 1'b0;
        chk("t6.wrap_seen", int'(seen), 1);
        chk("t6.frame_count_wrap", int'(fc[0]), 0);
        repeat (8) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/three_of_five_tx.md
Name: three_of_five_tx

Overview:
- Transmit side of the 3-of-5 constant-weight code link.
- Accepts decimal digits over a valid/ready handshake and maps each one to a 5-bit codeword with exactly three ones.
- Serializes the codeword LSB-first on a single line, with a frame strobe, so a downstream exactly-three-of-five checker can validate each received word.
- Sits between digit-producing logic and the serial link.

Parameters:
- BIT_CYCLES, 1, clock cycles each serial bit is held (legal range 1..255).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- digit_in  input  4  digit to send, 0..9 legal.
- digit_valid  input  1  digit_in valid.
- digit_ready  output  1  block can accept a digit this cycle.
- tx_bit  output  1  serial data, LSB of codeword first.
- tx_frame  output  1  high during all cycles of bit 0 of a frame.
- tx_active  output  1  high during all 5*BIT_CYCLES cycles of a frame.
- code_out  output  5  codeword of the current or most recent frame.
- err_pulse  output  1  one-cycle pulse when an illegal digit (>9) is consumed.
- frame_count  output  8  completed frames, wraps modulo 256.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. All outputs are registered.
- Reset values (while rst is high and in the cycle after): tx_bit=0, tx_frame=0, tx_active=0, digit_ready=0, err_pulse=0, code_out=5'b00000, frame_count=0.
  - digit_ready rises in the first cycle after rst deasserts.
- Encoding: digit d maps to the d-th 5-bit value (ascending) with popcount 3.
  - 0→00111, 1→01011, 2→01101, 3→01110, 4→10011
  - 5→10101, 6→10110, 7→11001, 8→11010, 9→11100
- FSM states:
  - IDLE: digit_ready=1, tx_active=0, tx_bit=0.
  - SHIFT: digit_ready=0.
- Handshake: a transfer occurs on an edge where digit_valid && digit_ready. digit_in is sampled only then. Holding digit_valid high in IDLE without a transfer is not possible, because ready is high.
- Legal digit accepted at edge k:
  - At edge k: code_out loads the codeword, the shift register loads, state goes to SHIFT.
  - From cycle k+1: tx_active=1, tx_frame=1, tx_bit=bit0.
- Bit timing:
  - Each bit is held for exactly BIT_CYCLES cycles, then the register shifts right.
  - The bit index runs 0..4; the cycle counter runs 0..BIT_CYCLES-1.
  - tx_frame is high only while bit index=0.
- Frame end: after the last cycle of bit 4, the next cycle has state=IDLE, tx_active=0, tx_bit=0, digit_ready=1, and frame_count incremented by 1 (255→0).
  - Minimum gap between frames is 1 idle cycle.
  - Frame period is 5*BIT_CYCLES+1 cycles under back-to-back valid.
- Illegal digit (10..15) accepted in IDLE:
  - Consumed. No frame, state stays IDLE, digit_ready stays 1.
  - err_pulse=1 in the next cycle only.
  - code_out and frame_count are unchanged.
- Back-to-back illegal digits produce consecutive err_pulse cycles, one per accepted digit.
- Invariant: whenever tx_active=1, popcount(code_out)=3, and the bits sent on tx_bit over the frame equal code_out LSB-first.
- digit_valid and digit_in are ignored while in SHIFT; no transfer occurs.
- Reset mid-frame: the frame is aborted immediately and all outputs take their reset values. No partial frame resumes, and frame_count is not incremented.
- BIT_CYCLES=1: the cycle counter degenerates, and a frame is exactly 5 cycles with tx_frame high for 1 cycle.

Test Plan:
1. Reset release, BIT_CYCLES=1, send digit 0 → digit_ready=1 one cycle after rst falls; tx_bit sequence 1,1,1,0,0; tx_frame high 1 cycle; tx_active 5 cycles; frame_count=1.
2. Send all digits 0..9 with digit_valid held high → ten frames, each code_out matching the table and popcount 3; 6-cycle period; frame_count=10; err_pulse never high.
3. Send digit 12, then digit 7 → err_pulse high exactly 1 cycle, no tx_active, frame_count unchanged; then a frame with tx_bit sequence 1,0,0,1,1 (code 11001).
4. BIT_CYCLES=3, digit 5 → 15-cycle frame; tx_bit 1,1,1,0,0,0,1,1,1,0,0,0,1,1,1; tx_frame high 3 cycles.
5. Assert rst during bit 2 of a frame for digit 9 → next cycle all outputs at reset values; after release, a new digit 1 transmits correctly (1,1,0,1,0) and frame_count=1.
6. Force frame_count to 255 by sending 256 legal digits → frame_count wraps to 0; changing digit_valid and digit_in during SHIFT has no effect on the frame in progress.
